// File: rtl/axi_mem_qos_sched_pkg.sv
// Shared types for the memory QoS scheduler: weight type, reset weights and
// the AXI request/response structs carried on both sides of the scheduler.
package axi_mem_qos_sched_pkg;

  localparam int unsigned WEIGHT_W = 4;
  localparam int unsigned NO_PORTS = 2;

  typedef logic [WEIGHT_W-1:0] qos_weight_t;

  // Element [0] is the CVA6 port, [1] is Ara.
  localparam qos_weight_t DEFAULT_WEIGHTS [NO_PORTS] = '{4'd2, 4'd6};

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_ax_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
    axi_r_t r;
    logic   r_valid;
  } axi_resp_t;

endpackage

// File: rtl/axi_mem_qos_sched_throttle.sv
// Per-port throttle: outstanding read/write counters, token budget and the
// AR/AW allow terms, plus the per-port contribution to the epoch refill.
module axi_port_throttle
  import axi_mem_qos_sched_pkg::*;
#(
  parameter int unsigned MaxRdTxns   = 8,
  parameter int unsigned MaxWrTxns   = 8,
  parameter int unsigned WeightWidth = WEIGHT_W,
  parameter logic [WeightWidth-1:0] DefaultWeight = '0
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             en_q,
  input  logic [WeightWidth-1:0]           w_q,
  input  logic                             refill,
  input  logic [WeightWidth-1:0]           refill_weight,
  input  logic                             ar_valid,
  input  logic                             ar_ready,
  input  logic                             aw_valid,
  input  logic                             aw_ready,
  input  logic                             r_done,
  input  logic                             b_done,
  output logic                             ar_allow,
  output logic                             aw_allow,
  output logic [$clog2(MaxRdTxns+1)-1:0]   rd_cnt,
  output logic [$clog2(MaxWrTxns+1)-1:0]   wr_cnt,
  output logic                             exhausted_or_idle,
  output logic                             idle_full
);

  localparam int unsigned RdCntW = $clog2(MaxRdTxns+1);
  localparam int unsigned WrCntW = $clog2(MaxWrTxns+1);
  localparam logic [RdCntW-1:0] RdMax = RdCntW'(MaxRdTxns);
  localparam logic [WrCntW-1:0] WrMax = WrCntW'(MaxWrTxns);

  logic [WeightWidth-1:0] tok;
  logic                   throttle, ar_hs, aw_hs, pend;
  logic [1:0]             used;
  logic [WeightWidth-1:0] tok_dec;

  assign throttle = en_q && (w_q != '0);
  assign pend     = ar_valid || aw_valid;

  // AR wins the last token; AW may only take it when AR is not asking.
  assign ar_allow = rst_ni && (rd_cnt < RdMax) && (!throttle || tok != '0);
  assign aw_allow = rst_ni && (wr_cnt < WrMax) &&
                    (!throttle || tok > WeightWidth'(1) ||
                     (tok == WeightWidth'(1) && !ar_valid));

  assign ar_hs = ar_valid && ar_ready && ar_allow;
  assign aw_hs = aw_valid && aw_ready && aw_allow;

  assign exhausted_or_idle = (tok == '0) || (w_q == '0) || !pend;
  assign idle_full         = (tok == w_q) && !pend;

  assign used    = 2'(ar_hs) + 2'(aw_hs);
  assign tok_dec = (tok > WeightWidth'(used)) ? tok - WeightWidth'(used) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      tok    <= DefaultWeight;
    end else begin
      case ({ar_hs, r_done})
        2'b10:   rd_cnt <= rd_cnt + RdCntW'(1);
        2'b01:   rd_cnt <= rd_cnt - RdCntW'(1);
        default: rd_cnt <= rd_cnt;
      endcase
      case ({aw_hs, b_done})
        2'b10:   wr_cnt <= wr_cnt + WrCntW'(1);
        2'b01:   wr_cnt <= wr_cnt - WrCntW'(1);
        default: wr_cnt <= wr_cnt;
      endcase
      if (refill)        tok <= refill_weight;
      else if (throttle) tok <= tok_dec;
    end
  end

  a_rd_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(r_done && !ar_hs && rd_cnt == '0));
  a_wr_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(b_done && !aw_hs && wr_cnt == '0));
  a_rd_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(ar_hs && !r_done && rd_cnt == RdMax));
  a_wr_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(aw_hs && !b_done && wr_cnt == WrMax));

endmodule

// File: rtl/axi_mem_qos_sched.sv
// Weighted-token / outstanding-limit scheduler in front of the shared AXI mux.
// Only AR/AW valid/ready are gated; every other field passes straight through.
module axi_mem_qos_sched
  import axi_mem_qos_sched_pkg::*;
#(
  parameter int unsigned NoPorts     = NO_PORTS,
  parameter int unsigned MaxRdTxns   = 8,
  parameter int unsigned MaxWrTxns   = 8,
  parameter int unsigned WeightWidth = WEIGHT_W,
  parameter logic [WeightWidth-1:0] DefaultWeights [NoPorts] = DEFAULT_WEIGHTS,
  parameter type req_t  = axi_mem_qos_sched_pkg::axi_req_t,
  parameter type resp_t = axi_mem_qos_sched_pkg::axi_resp_t
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic                                            en_i,
  input  logic [NoPorts-1:0][WeightWidth-1:0]             weight_i,
  input  req_t  [NoPorts-1:0]                             slv_reqs_i,
  output resp_t [NoPorts-1:0]                             slv_resps_o,
  output req_t  [NoPorts-1:0]                             mst_reqs_o,
  input  resp_t [NoPorts-1:0]                             mst_resps_i,
  output logic [NoPorts-1:0][$clog2(MaxRdTxns+1)-1:0]     rd_outstanding_o,
  output logic [NoPorts-1:0][$clog2(MaxWrTxns+1)-1:0]     wr_outstanding_o,
  output logic                                            busy_o
);

  logic                                en_q;
  logic [NoPorts-1:0][WeightWidth-1:0] w_q;
  logic [NoPorts-1:0]                  ar_allow, aw_allow, ex_idle, idle_full, ax_pend;
  logic                                refill;

  always_comb begin
    mst_reqs_o  = slv_reqs_i;
    slv_resps_o = mst_resps_i;
    for (int i = 0; i < NoPorts; i++) begin
      ax_pend[i]                = slv_reqs_i[i].ar_valid | slv_reqs_i[i].aw_valid;
      mst_reqs_o[i].ar_valid    = slv_reqs_i[i].ar_valid & ar_allow[i];
      mst_reqs_o[i].aw_valid    = slv_reqs_i[i].aw_valid & aw_allow[i];
      slv_resps_o[i].ar_ready   = mst_resps_i[i].ar_ready & ar_allow[i];
      slv_resps_o[i].aw_ready   = mst_resps_i[i].aw_ready & aw_allow[i];
    end
  end

  // A fully idle, already-full system skips refill so weight_i is not resampled.
  assign refill = (&ex_idle) && !(&idle_full);
  assign busy_o = |{rd_outstanding_o, wr_outstanding_o};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q <= 1'b0;
      for (int i = 0; i < NoPorts; i++) w_q[i] <= DefaultWeights[i];
    end else begin
      if (!(|ax_pend)) en_q <= en_i;
      if (refill)      w_q  <= weight_i;
    end
  end

  for (genvar i = 0; i < NoPorts; i++) begin : g_port
    axi_port_throttle #(
      .MaxRdTxns     (MaxRdTxns),
      .MaxWrTxns     (MaxWrTxns),
      .WeightWidth   (WeightWidth),
      .DefaultWeight (DefaultWeights[i])
    ) u_thr (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .en_q              (en_q),
      .w_q               (w_q[i]),
      .refill            (refill),
      .refill_weight     (weight_i[i]),
      .ar_valid          (slv_reqs_i[i].ar_valid),
      .ar_ready          (mst_resps_i[i].ar_ready),
      .aw_valid          (slv_reqs_i[i].aw_valid),
      .aw_ready          (mst_resps_i[i].aw_ready),
      .r_done            (mst_resps_i[i].r_valid & slv_reqs_i[i].r_ready & mst_resps_i[i].r.last),
      .b_done            (mst_resps_i[i].b_valid & slv_reqs_i[i].b_ready),
      .ar_allow          (ar_allow[i]),
      .aw_allow          (aw_allow[i]),
      .rd_cnt            (rd_outstanding_o[i]),
      .wr_cnt            (wr_outstanding_o[i]),
      .exhausted_or_idle (ex_idle[i]),
      .idle_full         (idle_full[i])
    );
  end

endmodule
